// File: rtl/ym3438_pkg.sv
// Shared YM3438 definitions: frame geometry, accumulator sizing and the
// conversion from the chip's offset-binary DAC slot format to two's complement.
package ym3438_pkg;

    localparam int unsigned FRAME_SLOTS = 24;
    localparam int unsigned ACC_W       = 14;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned SAMPLE_W    = 9;

    // Offset binary (0x100 = zero) to signed 9-bit: flip the MSB.
    function automatic logic signed [SAMPLE_W-1:0] slot_to_signed(input logic [SAMPLE_W-1:0] x);
        return {~x[SAMPLE_W-1], x[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/ym3438_frame_fifo.sv
// Small frame FIFO. The head word and valid flag are registered copies computed
// from the next-state view, so a push is visible right after its edge and the
// outputs never depend combinationally on the consumer handshake.
module ym3438_frame_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop_req,
    output logic              valid,
    output logic [DATA_W-1:0] head,
    output logic              drop
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [LVL_W-1:0] lvl_t;

    localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);
    localparam lvl_t DEPTH_L  = lvl_t'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    ptr_t              wr_ptr_r, rd_ptr_r;
    lvl_t              count_r;
    logic              valid_r;
    logic [DATA_W-1:0] head_r;

    logic              pop_s, push_ok_s, drop_s;
    lvl_t              count_after_pop_s, count_next_s;
    ptr_t              rd_next_s, wr_next_s;
    logic [DATA_W-1:0] head_next_s;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LAST_PTR) ? ptr_t'(0) : p + ptr_t'(1);
    endfunction

    // Next-state: pop is resolved first so a full FIFO can still take a push.
    always_comb begin
        pop_s             = valid_r & pop_req;
        count_after_pop_s = pop_s ? (count_r - lvl_t'(1)) : count_r;
        push_ok_s         = push & (count_after_pop_s != DEPTH_L);
        drop_s            = push & ~push_ok_s;
        rd_next_s         = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        wr_next_s         = push_ok_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        count_next_s      = push_ok_s ? (count_after_pop_s + lvl_t'(1)) : count_after_pop_s;
        if (count_next_s == lvl_t'(0)) begin
            head_next_s = '0;
        end else if (push_ok_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = din;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage, pointers and registered head/valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            head_r   <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
            end
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            valid_r  <= (count_next_s != lvl_t'(0));
            head_r   <= head_next_s;
        end
    end

    assign valid = valid_r;
    assign head  = head_r;
    assign drop  = drop_s;

endmodule

// File: rtl/ym3438_frame_mixer.sv
// Sums the 24 per-slot DAC samples of each YM3438 frame into one stereo sample,
// buffers completed frames for a consumer and flags dropped or misaligned frames.
module ym3438_frame_mixer
    import ym3438_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned OUT_SHIFT  = 2
) (
    input  logic        MCLK,
    input  logic        IC,
    input  logic        cyc_en,
    input  logic        frame_sync,
    input  logic [8:0]  MOL,
    input  logic [8:0]  MOR,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        ovf,
    output logic        sync_err,
    input  logic        flag_clr
);

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_SLOTS);

    acc_t             acc_l_r, acc_r_r;
    logic [CNT_W-1:0] cnt_r;
    logic             frame_bad_r;
    logic             ovf_r, sync_err_r;

    acc_t             samp_l_s, samp_r_s;
    logic             cnt_full_s, push_s, sync_evt_s, drop_s;
    logic [31:0]      fifo_head_s;

    function automatic acc_t widen(input logic signed [SAMPLE_W-1:0] s);
        return {{(ACC_W - SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

    function automatic logic [15:0] to_out(input acc_t a);
        logic [15:0] ext;
        ext = {{(16 - ACC_W){a[ACC_W-1]}}, a};
        return ext << OUT_SHIFT;
    endfunction

    // Sample conversion and frame-boundary decisions.
    always_comb begin
        samp_l_s   = widen(slot_to_signed(MOL));
        samp_r_s   = widen(slot_to_signed(MOR));
        cnt_full_s = (cnt_r == CNT_FULL);
        // An over-long frame is corrupt even though cnt reached 24, so it is discarded too.
        push_s     = cyc_en & frame_sync & cnt_full_s & ~frame_bad_r;
        sync_evt_s = cyc_en & ((frame_sync & ~cnt_full_s & (cnt_r != CNT_W'(0)))
                             | (~frame_sync & cnt_full_s));
    end

    // Per-side accumulators and slot counter; idle while cyc_en is low.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            acc_l_r     <= '0;
            acc_r_r     <= '0;
            cnt_r       <= '0;
            frame_bad_r <= 1'b0;
        end else if (cyc_en) begin
            if (frame_sync) begin
                acc_l_r     <= samp_l_s;
                acc_r_r     <= samp_r_s;
                cnt_r       <= CNT_W'(1);
                frame_bad_r <= 1'b0;
            end else if (!cnt_full_s) begin
                acc_l_r     <= acc_l_r + samp_l_s;
                acc_r_r     <= acc_r_r + samp_r_s;
                cnt_r       <= cnt_r + CNT_W'(1);
                frame_bad_r <= frame_bad_r;
            end else begin
                frame_bad_r <= 1'b1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sticky status flags; a new event outranks a simultaneous clear.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            ovf_r      <= 1'b0;
            sync_err_r <= 1'b0;
        end else begin
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (flag_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (sync_evt_s) begin
                sync_err_r <= 1'b1;
            end else if (flag_clr) begin
                sync_err_r <= 1'b0;
            end else begin
                sync_err_r <= sync_err_r;
            end
        end
    end

    ym3438_frame_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (32)
    ) u_fifo (
        .clk     (MCLK),
        .rst_n   (IC),
        .push    (push_s),
        .din     ({to_out(acc_l_r), to_out(acc_r_r)}),
        .pop_req (out_ready),
        .valid   (out_valid),
        .head    (fifo_head_s),
        .drop    (drop_s)
    );

    assign out_l    = fifo_head_s[31:16];
    assign out_r    = fifo_head_s[15:0];
    assign ovf      = ovf_r;
    assign sync_err = sync_err_r;

endmodule

// File: tb/tb_ym3438_frame_mixer.sv
// Directed bench for ym3438_frame_mixer: expected frames go into a scoreboard
// queue when their push is stimulated; a negedge monitor compares every pop.
module tb_ym3438_frame_mixer;

    logic        MCLK = 1'b0;
    logic        IC = 1'b0;
    logic        cyc_en = 1'b0;
    logic        frame_sync = 1'b0;
    logic [8:0]  MOL = 9'h100;
    logic [8:0]  MOR = 9'h100;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_l, out_r;
    logic        ovf, sync_err;
    logic        flag_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    ym3438_frame_mixer #(.FIFO_DEPTH(2), .OUT_SHIFT(2)) dut (
        .MCLK(MCLK), .IC(IC), .cyc_en(cyc_en), .frame_sync(frame_sync),
        .MOL(MOL), .MOR(MOR), .out_valid(out_valid), .out_ready(out_ready),
        .out_l(out_l), .out_r(out_r), .ovf(ovf), .sync_err(sync_err),
        .flag_clr(flag_clr)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next posedge whenever valid and ready are high.
    always @(negedge MCLK) begin
        if (IC && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_frame: got 0x%0h, expected no frame", {out_l, out_r});
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({out_l, out_r} !== e) begin
                    failures++;
                    $display("FAIL frame_data: got 0x%0h, expected 0x%0h", {out_l, out_r}, e);
                end
            end
        end
    end

    task automatic step(input logic en, input logic sync, input logic [8:0] l,
                        input logic [8:0] r, input logic clr);
        cyc_en = en; frame_sync = sync; MOL = l; MOR = r; flag_clr = clr;
        @(posedge MCLK);
        #1;
        cyc_en = 1'b0; frame_sync = 1'b0; flag_clr = 1'b0;
    endtask

    task automatic body(input logic [8:0] l, input logic [8:0] r, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, l, r, 1'b0);
    endtask

    // Sync cycle starting a new frame; if push is set the previous frame is expected.
    task automatic sync_push(input logic [8:0] l, input logic [8:0] r, input logic push,
                             input logic [15:0] el, input logic [15:0] er);
        if (push) exp_q.push_back({el, er});
        step(1'b1, 1'b1, l, r, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge MCLK);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", {out_l, out_r}, 32'd0);
        check("rst_flags", {30'd0, ovf, sync_err}, 32'd0);
        #2 IC = 1'b1;
        @(posedge MCLK); #1;

        // Full scale: 24 x +255 = 6120 -> 0x5FA0, 24 x -256 = -6144 -> 0xA000.
        sync_push(9'h1FF, 9'h000, 1'b0, 16'h0, 16'h0);
        body(9'h1FF, 9'h000, 23);
        check("pre_push_valid", {31'd0, out_valid}, 32'd0);
        sync_push(9'h100, 9'h100, 1'b1, 16'h5FA0, 16'hA000);
        check("push_valid", {31'd0, out_valid}, 32'd1);
        check("fs_out_l", {16'd0, out_l}, 32'h5FA0);
        check("fs_out_r", {16'd0, out_r}, 32'hA000);
        check("first_sync_silent", {31'd0, sync_err}, 32'd0);
        out_ready = 1'b1;

        // Silence: three zero frames.
        body(9'h100, 9'h100, 23);
        sync_push(9'h100, 9'h100, 1'b1, 16'h0, 16'h0);
        body(9'h100, 9'h100, 23);
        sync_push(9'h100, 9'h100, 1'b1, 16'h0, 16'h0);
        body(9'h100, 9'h100, 23);
        sync_push(9'h180, 9'h080, 1'b1, 16'h0, 16'h0);
        check("silence_flags", {30'd0, ovf, sync_err}, 32'd0);

        // Backpressure: +3072 -> 0x3000 / -3072 -> 0xD000, +24 -> 0x0060 / -24 -> 0xFFA0.
        body(9'h180, 9'h080, 23);
        out_ready = 1'b0;
        sync_push(9'h101, 9'h0FF, 1'b1, 16'h3000, 16'hD000);
        body(9'h101, 9'h0FF, 23);
        sync_push(9'h000, 9'h1FF, 1'b1, 16'h0060, 16'hFFA0);
        body(9'h000, 9'h1FF, 23);
        check("bp_no_ovf_yet", {31'd0, ovf}, 32'd0);
        sync_push(9'h100, 9'h100, 1'b0, 16'h0, 16'h0);
        check("bp_ovf", {31'd0, ovf}, 32'd1);
        check("bp_count", 32'(dut.u_fifo.count_r), 32'd2);
        check("bp_head_kept", {16'd0, out_l}, 32'h3000);
        out_ready = 1'b1;
        step(1'b0, 1'b0, 9'h1FF, 9'h1FF, 1'b0);
        step(1'b0, 1'b0, 9'h1FF, 9'h1FF, 1'b1);
        step(1'b0, 1'b0, 9'h1FF, 9'h1FF, 1'b0);
        check("ovf_cleared", {31'd0, ovf}, 32'd0);
        check("drained", {31'd0, out_valid}, 32'd0);

        // Full FIFO with simultaneous pop and push: +384 -> 0x0600, -384 -> 0xFA00.
        out_ready = 1'b0;
        body(9'h100, 9'h100, 23);
        sync_push(9'h110, 9'h0F0, 1'b1, 16'h0, 16'h0);
        body(9'h110, 9'h0F0, 23);
        sync_push(9'h100, 9'h101, 1'b1, 16'h0600, 16'hFA00);
        body(9'h100, 9'h101, 23);
        check("full_count", 32'(dut.u_fifo.count_r), 32'd2);
        out_ready = 1'b1;
        sync_push(9'h100, 9'h100, 1'b1, 16'h0000, 16'h0060);
        out_ready = 1'b0;
        check("pp_count", 32'(dut.u_fifo.count_r), 32'd2);
        check("pp_no_ovf", {31'd0, ovf}, 32'd0);
        check("pp_head", {16'd0, out_l}, 32'h0600);
        out_ready = 1'b1;
        body(9'h100, 9'h100, 23);

        // Short frame (20 cycles) then long frame (26 cycles).
        sync_push(9'h100, 9'h100, 1'b1, 16'h0, 16'h0);
        body(9'h100, 9'h100, 19);
        sync_push(9'h100, 9'h100, 1'b0, 16'h0, 16'h0);
        check("short_sync_err", {31'd0, sync_err}, 32'd1);
        check("short_no_push", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b0, 9'h100, 9'h100, 1'b1);
        check("clr_sync_err", {31'd0, sync_err}, 32'd0);
        body(9'h100, 9'h100, 23);
        check("exact_no_err", {31'd0, sync_err}, 32'd0);
        step(1'b1, 1'b0, 9'h100, 9'h100, 1'b1);
        check("set_wins", {31'd0, sync_err}, 32'd1);
        step(1'b1, 1'b0, 9'h100, 9'h100, 1'b0);
        sync_push(9'h100, 9'h100, 1'b0, 16'h0, 16'h0);
        check("long_no_push", {31'd0, out_valid}, 32'd0);
        check("long_sync_err", {31'd0, sync_err}, 32'd1);
        step(1'b0, 1'b0, 9'h100, 9'h100, 1'b1);
        check("clr_again", {31'd0, sync_err}, 32'd0);

        // Reset at cycle 12 of a frame with one frame buffered.
        body(9'h100, 9'h100, 23);
        out_ready = 1'b0;
        sync_push(9'h1FF, 9'h1FF, 1'b0, 16'h0, 16'h0);
        check("one_buffered", {31'd0, out_valid}, 32'd1);
        body(9'h1FF, 9'h1FF, 11);
        #2 IC = 1'b0;
        #1;
        check("rst_valid_now", {31'd0, out_valid}, 32'd0);
        check("rst_out_now", {out_l, out_r}, 32'd0);
        exp_q.delete();
        #2 IC = 1'b1;
        @(posedge MCLK); #1;
        sync_push(9'h1FF, 9'h1FF, 1'b0, 16'h0, 16'h0);
        check("post_rst_no_push", {31'd0, out_valid}, 32'd0);
        check("post_rst_no_err", {31'd0, sync_err}, 32'd0);
        // Idle cycles with cyc_en low carry garbage samples that must be ignored.
        body(9'h1FF, 9'h1FF, 10);
        step(1'b0, 1'b0, 9'h000, 9'h000, 1'b0);
        step(1'b0, 1'b0, 9'h000, 9'h000, 1'b0);
        step(1'b0, 1'b0, 9'h000, 9'h000, 1'b0);
        body(9'h1FF, 9'h1FF, 13);
        out_ready = 1'b1;
        sync_push(9'h100, 9'h100, 1'b1, 16'h5FA0, 16'h5FA0);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_out", {out_l, out_r}, 32'h5FA0_5FA0);
        repeat (3) step(1'b0, 1'b0, 9'h100, 9'h100, 1'b0);
        check("final_empty", {31'd0, out_valid}, 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("final_flags", {30'd0, ovf, sync_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
